// File: rtl/tele_ctrl_mc.sv
// Remote power-control command engine: per-channel synchronise and debounce,
// activity gating, fixed-priority arbitration, then pulse or level execution and a hold-off.
module tele_ctrl_mc #(
  parameter int                 NUM_CH         = 3,
  parameter int                 SYNC_STAGES    = 2,
  parameter int                 DEB_CYCLES     = 32,
  parameter int                 PULSE_CYCLES   = 8192,
  parameter int                 HOLDOFF_CYCLES = 32768,
  parameter logic [NUM_CH-1:0]  PULSE_MASK     = {NUM_CH{1'b1}}
) (
  input  logic              i_clk_32k,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_cmd_n,
  input  logic              i_act_n,
  input  logic              i_int_clr,
  output logic [NUM_CH-1:0] o_cmd,
  output logic              o_busy,
  output logic              o_int
);

  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int TMAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_HOLDOFF} state_t;

  logic [NUM_CH-1:0]      cmd_sync_reg [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] act_sync_reg;
  logic [NUM_CH-1:0]      cmd_sync_n;
  logic                   act_sync_n;

  logic [DW-1:0]     deb_cnt_reg  [NUM_CH];
  logic [DW-1:0]     deb_cnt_next [NUM_CH];
  logic [NUM_CH-1:0] filt_n_reg, filt_n_next;
  logic [NUM_CH-1:0] arm_reg, arm_next, arm_clr;
  logic [NUM_CH-1:0] req;

  state_t            state_reg, state_next;
  logic [TW-1:0]     cnt_reg, cnt_next;
  logic [CW-1:0]     ch_reg, ch_next, sel;
  logic [NUM_CH-1:0] cmd_reg, cmd_next, sel_onehot;
  logic              busy_reg, int_reg, int_next, accept;

  // Preset to 1 so commands and the activity gate both start inactive.
  always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) cmd_sync_reg[s] <= '1;
      act_sync_reg <= '1;
    end else begin
      cmd_sync_reg[0] <= i_cmd_n;
      for (int s = 1; s < SYNC_STAGES; s++) cmd_sync_reg[s] <= cmd_sync_reg[s-1];
      act_sync_reg <= {act_sync_reg[SYNC_STAGES-2:0], i_act_n};
    end
  end

  assign cmd_sync_n = cmd_sync_reg[SYNC_STAGES-1];
  assign act_sync_n = act_sync_reg[SYNC_STAGES-1];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic diff, done;
      assign diff              = cmd_sync_n[gi] ^ filt_n_reg[gi];
      assign done              = diff && (deb_cnt_reg[gi] == DEB_LAST);
      assign deb_cnt_next[gi]  = (!diff || done) ? '0 : deb_cnt_reg[gi] + 1'b1;
      assign filt_n_next[gi]   = done ? cmd_sync_n[gi] : filt_n_reg[gi];
      assign arm_next[gi]      = arm_clr[gi] ? 1'b0 : (filt_n_reg[gi] | arm_reg[gi]);
      assign req[gi]           = ~filt_n_reg[gi] & arm_reg[gi] & ~act_sync_n;
    end
  endgenerate

  always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) deb_cnt_reg[c] <= '0;
      filt_n_reg <= '1;
      arm_reg    <= '1;
    end else begin
      for (int c = 0; c < NUM_CH; c++) deb_cnt_reg[c] <= deb_cnt_next[c];
      filt_n_reg <= filt_n_next;
      arm_reg    <= arm_next;
    end
  end

  // Lowest index wins.
  always_comb begin
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) sel = CW'(i);
    end
  end

  assign sel_onehot = NUM_CH'(1) << sel;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ch_next    = ch_reg;
    cmd_next   = cmd_reg;
    arm_clr    = '0;
    accept     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cmd_next = '0;
        if (|req) begin
          accept     = 1'b1;
          ch_next    = sel;
          arm_clr    = sel_onehot;
          cmd_next   = sel_onehot;
          cnt_next   = '0;
          state_next = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (act_sync_n || (PULSE_MASK[ch_reg] ? (cnt_reg == PULSE_LAST) : filt_n_reg[ch_reg])) begin
          cmd_next   = '0;
          cnt_next   = '0;
          state_next = S_HOLDOFF;
        end else if (PULSE_MASK[ch_reg]) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_HOLDOFF: begin
        cmd_next = '0;
        if (cnt_reg == HOLD_LAST) begin
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        cmd_next   = '0;
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  // A new accept outranks a simultaneous clear.
  assign int_next = accept | (int_reg & ~i_int_clr);

  always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      ch_reg    <= '0;
      cmd_reg   <= '0;
      busy_reg  <= 1'b0;
      int_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ch_reg    <= ch_next;
      cmd_reg   <= cmd_next;
      busy_reg  <= (state_next != S_IDLE);
      int_reg   <= int_next;
    end
  end

  assign o_cmd  = cmd_reg;
  assign o_busy = busy_reg;
  assign o_int  = int_reg;

endmodule
